// File: rtl/my_aes_decipher.sv
// -----------------------------------------------------------------------------
// my_aes_decipher -- iterative AES-128 inverse cipher, one round per clock.
//
// Decrypts one 128-bit ciphertext block using round keys 0..10 that are
// written from outside through an indexed write port. No key expansion here.
// Latency is 11 cycles from the accepting edge to the result_valid pulse.
//
// Ports:
//   clk                 clock, rising edge
//   rst                 asynchronous active-high reset
//   next                start request, sampled only while idle
//   init_round[3:0]     round-key index to write (0..10, others ignored)
//   init_roundkey[127:0] round-key value
//   init_roundkey_valid round-key write strobe (honoured only while idle)
//   block[127:0]        ciphertext, captured on an accepted next
//   plainblock[127:0]   plaintext / working state
//   result_valid        one-cycle pulse when plainblock holds the result
//   is_idle             high while the block can accept next / key writes
//
// Build option:
//   MY_AES_DECIPHER_OUT_MASK_EN -- when defined, plainblock reads as zero
//   except in the result_valid cycle, so intermediate state is never visible.
//
// Byte order: byte 0 = [127:120], column c = bytes 4c..4c+3, row r of
// column c is byte 4c+r.
// -----------------------------------------------------------------------------

// Byte-wise inverse S-box over a 128-bit word. Each byte is computed as the
// GF(2^8) inverse of the inverse affine transform of the input byte; the
// multiplicative inverse is x^254, formed by repeated squaring.
module aes_inv_sbox (
  input  logic [127:0] sboxw,
  output logic [127:0] new_sboxw
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] inv_sbox_byte(input logic [7:0] y);
    logic [7:0] t;
    logic [7:0] pw;
    logic [7:0] acc;
    // Inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05
    t   = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    // x^254 = x^2 * x^4 * ... * x^128 (zero maps to zero)
    pw  = t;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      pw  = gf_mul(pw, pw);
      acc = gf_mul(acc, pw);
    end
    return acc;
  endfunction

  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    assign new_sboxw[8*gi +: 8] = inv_sbox_byte(sboxw[8*gi +: 8]);
  end

endmodule

module my_aes_decipher #(
  parameter int AES128_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         next,
  input  logic [3:0]   init_round,
  input  logic [127:0] init_roundkey,
  input  logic         init_roundkey_valid,
  input  logic [127:0] block,
  output logic [127:0] plainblock,
  output logic         result_valid,
  output logic         is_idle
);

  localparam logic [3:0] LAST_ROUND = 4'(AES128_ROUNDS);

  typedef enum logic {ST_IDLE, ST_DEC} state_t;

  state_t       state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic         first_q, first_d;
  logic [127:0] block_q, block_d;
  logic         result_valid_q, result_valid_d;

  logic [127:0] keys_q [0:AES128_ROUNDS];

  logic [127:0] round_key;
  logic [127:0] shifted;
  logic [127:0] subbed;
  logic [127:0] added;
  logic [127:0] mixed;
  logic         key_we;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // One InvMixColumns column; multiples built from x2/x4/x8 of each byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // InvShiftRows: output column c row r comes from input column (c-r) mod 4.
  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    for (genvar gj = 0; gj < 4; gj++) begin : g_row
      assign shifted[127-8*(4*gi+gj) -: 8] =
        block_q[127-8*(4*((gi-gj+4)%4)+gj) -: 8];
    end
    assign mixed[127-32*gi -: 32] = inv_mix_col(added[127-32*gi -: 32]);
  end

  aes_inv_sbox u_inv_sbox (
    .sboxw     (shifted),
    .new_sboxw (subbed)
  );

  assign round_key = keys_q[round_q];
  assign added     = subbed ^ round_key;
  assign is_idle   = (state_q == ST_IDLE);
  assign key_we    = init_roundkey_valid && (init_round <= LAST_ROUND) && is_idle;

  always_comb begin
    state_d        = state_q;
    round_d        = round_q;
    first_d        = first_q;
    block_d        = block_q;
    result_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (next) begin
          block_d = block;
          round_d = LAST_ROUND;
          first_d = 1'b1;
          state_d = ST_DEC;
        end
      end
      ST_DEC: begin
        if (first_q) begin
          // Initial AddRoundKey with the last round key.
          block_d = block_q ^ round_key;
          round_d = round_q - 4'd1;
          first_d = 1'b0;
        end else if (round_q != 4'd0) begin
          block_d = mixed;
          round_d = round_q - 4'd1;
        end else begin
          // Final round has no InvMixColumns.
          block_d        = added;
          state_d        = ST_IDLE;
          result_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      round_q        <= 4'd0;
      first_q        <= 1'b0;
      block_q        <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      round_q        <= round_d;
      first_q        <= first_d;
      block_q        <= block_d;
      result_valid_q <= result_valid_d;
    end
  end

  // Key store is cleared by reset, so it is held in flops rather than RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= AES128_ROUNDS; i++) keys_q[i] <= '0;
    end else if (key_we) begin
      keys_q[init_round] <= init_roundkey;
    end
  end

  assign result_valid = result_valid_q;

`ifdef MY_AES_DECIPHER_OUT_MASK_EN
  assign plainblock = result_valid_q ? block_q : 128'h0;
`else
  assign plainblock = block_q;
`endif

endmodule

// File: doc/my_aes_decipher.md
# my_aes_decipher

Iterative AES-128 inverse cipher (FIPS-197 InvCipher) that processes one round per clock, for the decrypt path of the AES core. It accepts a 128-bit ciphertext block and returns the 128-bit plaintext after a fixed latency. Round keys 0..10 are loaded externally through an indexed write port. No key expansion is done in this block.

## Interface
- `AES128_ROUNDS`, default 10: number of rounds; also the highest valid round-key index.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `next` input 1: start request; sampled only while idle.
- `init_round` input 4: round-key index to write (0..10).
- `init_roundkey` input 128: round-key value.
- `init_roundkey_valid` input 1: round-key write strobe.
- `block` input 128: ciphertext; captured on an accepted `next`.
- `plainblock` output 128: plaintext / working state register.
- `result_valid` output 1: one-cycle pulse when `plainblock` holds the final result.
- `is_idle` output 1: high in IDLE; the block accepts `next` only when this is high.

## Operation
- Byte order:
  - Byte 0 = `[127:120]`.
  - Columns are `w0=[127:96]` .. `w3=[31:0]`.
  - Row r of column c is byte 4c+r.
- Key memory:
  - 11 x 128-bit entries.
  - A write occurs when `init_roundkey_valid` is high and `init_round` <= 10 and `is_idle`=1.
  - The write is ignored if `init_round` > 10 or the block is busy.
  - Entries hold their value until rewritten or reset.
- InvSubBytes uses a combinational `aes_inv_sbox` instance: 128-bit in/out, byte-wise inverse S-box, with ports `sboxw`/`new_sboxw`.
- States:
  - IDLE:
    - If `next`=1: `block_reg`<=`block`, `round`<=10, go to DEC.
    - Otherwise hold `block_reg`.
  - DEC, first cycle (`round`=10, first pass flagged by the internal `first` bit): `block_reg`<=`block_reg` ^ key[10]; `round`<=9.
  - DEC, `round` in 9..1: `block_reg`<=InvMixColumns(InvSubBytes(InvShiftRows(`block_reg`)) ^ key[`round`]); `round` decrements.
  - DEC, `round`=0: `block_reg`<=InvSubBytes(InvShiftRows(`block_reg`)) ^ key[0]; go to IDLE; `result_valid`<=1.
- InvShiftRows: row r rotates right by r, i.e. out column c row r = in column (c-r) mod 4 row r.
- InvMixColumns coefficients: {0e,0b,0d,09}, GF(2^8) with reduction polynomial 0x11b.
- `next` asserted while busy is ignored; it is not queued.
- `result_valid` is high for exactly one cycle per accepted `next`.

## Timing
- Reset values (immediate, asynchronous):
  - `plainblock`=0, `result_valid`=0, `is_idle`=1.
  - `round`=0, state IDLE, all key entries 0.
- Latency:
  - `next` accepted at edge E0.
  - Round operations occur on edges E1..E11.
  - `result_valid`=1 and the final `plainblock` appear after E11, i.e. 11 cycles after acceptance.
  - `is_idle` rises after E11, in the same cycle as `result_valid`.
- Back-to-back: `next` held high in the `result_valid` cycle is accepted at that edge, so throughput is one block per 12 cycles.
- A key write and `next` in the same idle cycle both take effect. Decryption uses the new key only if its index is used at or after E1; key[10] written at E0 is used at E1.
- `plainblock` shows intermediate states during DEC and holds its value in IDLE, except when masked (see Configuration).
- `rst` asserted mid-operation aborts immediately. No `result_valid` is produced, and keys must be reloaded.

## Configuration
- Macro: `MY_AES_DECIPHER_OUT_MASK_EN`.
- Defined: `plainblock` = `result_valid` ? `block_reg` : 128'h0, so intermediate and stale state is never exposed.
- Undefined: `plainblock` = `block_reg` at all times.
- Latency and `result_valid` are identical in both builds.

## Test plan
- FIPS-197 C.1: load the expansion of key 000102030405060708090a0b0c0d0e0f (key[0]=000102..0f, key[10]=13111d7fe3944a17f307a78b4d2b30c5), then `next` with block 69c4e0d86a7b0430d8cdb78070b4c55a -> after 11 cycles `result_valid` pulses and `plainblock`=00112233445566778899aabbccddeeff.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, block 3925841d02dc09fbdc118597196a0b32 -> `plainblock`=3243f6a8885a308d313198a2e0370734; then a back-to-back second `next` in the `result_valid` cycle -> second result 12 cycles later.
- `next` pulsed at busy cycles 3 and 7 -> ignored, with exactly one `result_valid`. Key write to index 5 while busy -> key[5] unchanged, result still correct.
- Write with `init_round`=11 or 15 -> no key entry changes; subsequent C.1 decrypt still correct.
- Assert `rst` at round 5 -> outputs 0, `is_idle`=1 immediately; a `next` without reloading keys yields the decryption with all-zero keys, and a C.1 decrypt after reloading keys is correct.
- Build with `MY_AES_DECIPHER_OUT_MASK_EN` -> `plainblock`=0 in every cycle except the `result_valid` cycle; build without it -> `plainblock` equals 69c4..^key[10] one cycle after acceptance.
